// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns host frames into register-table write/read cycles
module spi_reg_bridge #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] addr_r,
  input  logic [DATA_WIDTH-1:0] spi_dout,
  output logic                  xfer_abort
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, CMD, RD_FETCH, WR_DATA, RD_DATA} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic [SYNC_STAGES:0] settle;
  logic sclk_prev, cs_prev, sclk_s, cs_s, mosi_s;
  logic rise, fall, cs_fall, cs_rise, last;
  logic [BW-1:0] bit_cnt;
  logic [1:0] fetch_cnt;
  logic [DATA_WIDTH-1:0] rx_sr, tx_sr, rx_next;
  logic [ADDR_WIDTH-1:0] word_addr;
  // edge flags; settle masks the false cs_n fall seen while the synchronizer refills after reset
  always_comb begin
    sclk_s  = sclk_sync[SYNC_STAGES-1];
    cs_s    = cs_sync[SYNC_STAGES-1];
    mosi_s  = mosi_sync[SYNC_STAGES-1];
    rise    = sclk_s & ~sclk_prev & ~cs_prev;
    fall    = ~sclk_s & sclk_prev & ~cs_prev;
    cs_fall = settle[SYNC_STAGES] & cs_prev & ~cs_s;
    cs_rise = cs_s & ~cs_prev;
    rx_next = {rx_sr[DATA_WIDTH-2:0], mosi_s};
    last    = rise && bit_cnt == ((state == CMD) ? BW'(ADDR_WIDTH) : BW'(DATA_WIDTH - 1));
  end
  // input synchronizers plus one-clk history for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      settle    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
    end
  end
  // frame FSM; a cs_n rise overrides the state update, but a word completing on that clk still writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      fetch_cnt  <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      word_addr  <= '0;
      addr       <= '0;
      din        <= '0;
      wr         <= 1'b0;
      addr_r     <= '0;
      spi_miso   <= 1'b0;
      xfer_abort <= 1'b0;
    end else begin
      wr         <= 1'b0;
      xfer_abort <= 1'b0;
      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          bit_cnt  <= '0;
          if (cs_fall) state <= CMD;
        end
        CMD: if (rise) begin
          rx_sr   <= rx_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (last) begin
            bit_cnt   <= '0;
            word_addr <= rx_next[ADDR_WIDTH-1:0];
            if (rx_next[ADDR_WIDTH]) state <= WR_DATA;
            else begin
              state  <= RD_FETCH;
              addr_r <= rx_next[ADDR_WIDTH-1:0];
            end
          end
        end
        RD_FETCH: begin
          spi_miso  <= 1'b0;
          fetch_cnt <= fetch_cnt + 1'b1;
          if (fetch_cnt == 2'd2) begin
            fetch_cnt <= '0;
            tx_sr     <= spi_dout;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (fall) begin
            spi_miso <= tx_sr[DATA_WIDTH-1];
            tx_sr    <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
          end
          if (rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              bit_cnt  <= '0;
              addr_r   <= addr_r + 1'b1;
              spi_miso <= 1'b0;
              state    <= RD_FETCH;
            end
          end
        end
        WR_DATA: if (rise) begin
          rx_sr   <= rx_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (last) begin
            bit_cnt   <= '0;
            wr        <= 1'b1;
            addr      <= word_addr;
            din       <= rx_next;
            word_addr <= word_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (cs_rise && state != IDLE) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        fetch_cnt  <= '0;
        spi_miso   <= 1'b0;
        xfer_abort <= !last && (state == CMD || bit_cnt != '0 || rise);
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed SPI frames against spi_reg_bridge with a behavioural register table
module tb_spi_reg_bridge;
  logic clk = 0, rst = 0, spi_sclk = 0, spi_cs_n = 1, spi_mosi = 0;
  logic spi_miso, wr, xfer_abort;
  logic [6:0] addr, addr_r;
  logic [15:0] din, spi_dout;
  int vectors = 0, miscompares = 0, wr_cnt = 0, ab_cnt = 0;
  logic [6:0] wa [16];
  logic [15:0] wd [16];

  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .addr(addr), .wr(wr), .din(din), .addr_r(addr_r),
    .spi_dout(spi_dout), .xfer_abort(xfer_abort)
  );

  always #5 clk = ~clk;

  // register table: 0x10 holds 0xA5C3, every other address reads 0x1000 + address
  always_comb spi_dout = (addr_r == 7'h10) ? 16'hA5C3 : 16'h1000 + {9'd0, addr_r};

  // log write strobes and abort pulses away from the active edge
  always @(negedge clk) begin
    if (wr && wr_cnt < 16) begin
      wa[wr_cnt] = addr;
      wd[wr_cnt] = din;
    end
    if (wr) wr_cnt++;
    if (xfer_abort) ab_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    #100 spi_sclk = 1;
    r = spi_miso;
    #100 spi_sclk = 0;
  endtask

  task automatic xfer(input logic [15:0] v, input int n, output logic [15:0] r);
    logic b;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], b);
      r = {r[14:0], b};
    end
  endtask

  task automatic cs_lo();
    spi_cs_n = 0;
    #100;
  endtask

  task automatic cs_hi();
    #100 spi_cs_n = 1;
    #300;
  endtask

  initial begin
    logic [15:0] r;
    int bw, ba;
    repeat (10) @(negedge clk) spi_sclk = ~spi_sclk;
    spi_sclk = 0;
    chk("rst_addr", addr, 0);
    chk("rst_din", din, 0);
    chk("rst_addr_r", addr_r, 0);
    chk("rst_wr", wr, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_abort", xfer_abort, 0);
    @(negedge clk) rst = 1;
    repeat (5) @(negedge clk);

    bw = wr_cnt; ba = ab_cnt;
    cs_lo(); xfer(16'h0090, 8, r); xfer(16'h00F0, 16, r); cs_hi();
    chk("single_wr_count", wr_cnt - bw, 1);
    chk("single_wr_addr", wa[bw], 7'h10);
    chk("single_wr_din", wd[bw], 16'h00F0);
    chk("single_hold_addr", addr, 7'h10);
    chk("single_hold_din", din, 16'h00F0);
    chk("single_no_abort", ab_cnt - ba, 0);

    bw = wr_cnt; ba = ab_cnt;
    cs_lo(); xfer(16'h0093, 8, r);
    xfer(16'h00F1, 16, r); xfer(16'h00F2, 16, r); xfer(16'h00F3, 16, r); cs_hi();
    chk("burst_wr_count", wr_cnt - bw, 3);
    chk("burst_addr0", wa[bw], 7'h13);
    chk("burst_din0", wd[bw], 16'h00F1);
    chk("burst_addr1", wa[bw+1], 7'h14);
    chk("burst_din1", wd[bw+1], 16'h00F2);
    chk("burst_addr2", wa[bw+2], 7'h15);
    chk("burst_din2", wd[bw+2], 16'h00F3);
    chk("burst_no_abort", ab_cnt - ba, 0);

    bw = wr_cnt; ba = ab_cnt;
    cs_lo(); xfer(16'h0010, 8, r);
    chk("rd_addr_r", addr_r, 7'h10);
    xfer(16'h0000, 16, r);
    chk("rd_data", r, 16'hA5C3);
    chk("rd_addr_r_next", addr_r, 7'h11);
    cs_hi();
    chk("rd_miso_idle", spi_miso, 0);

    cs_lo(); xfer(16'h007F, 8, r);
    chk("brd_addr_r", addr_r, 7'h7F);
    xfer(16'h0000, 16, r);
    chk("brd_word0", r, 16'h107F);
    chk("brd_wrap", addr_r, 7'h00);
    xfer(16'h0000, 16, r);
    chk("brd_word1", r, 16'h1000);
    chk("brd_addr_r_end", addr_r, 7'h01);
    cs_hi();
    chk("rd_no_wr", wr_cnt - bw, 0);
    chk("rd_no_abort", ab_cnt - ba, 0);

    bw = wr_cnt; ba = ab_cnt;
    cs_lo(); xfer(16'h0092, 8, r); xfer(16'h00AB, 8, r);
    @(negedge clk) rst = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    chk("midrst_addr", addr, 0);
    chk("midrst_din", din, 0);
    xfer(16'h00CD, 8, r); cs_hi();
    chk("midrst_no_wr", wr_cnt - bw, 0);
    chk("midrst_no_abort", ab_cnt - ba, 0);

    bw = wr_cnt; ba = ab_cnt;
    cs_lo(); xfer(16'h0091, 8, r); xfer(16'h01FF, 9, r); cs_hi();
    chk("abort_no_wr", wr_cnt - bw, 0);
    chk("abort_pulse", ab_cnt - ba, 1);
    chk("abort_hold_addr", addr, 0);
    bw = wr_cnt; ba = ab_cnt;
    cs_lo(); xfer(16'h0091, 8, r); xfer(16'h1234, 16, r); cs_hi();
    chk("post_abort_wr_count", wr_cnt - bw, 1);
    chk("post_abort_addr", wa[bw], 7'h11);
    chk("post_abort_din", wd[bw], 16'h1234);
    chk("post_abort_no_abort", ab_cnt - ba, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
